bsg_sync_sync_handshake_rx: RTL and testbench

//  Receive-side controller for moving a multi-bit bundle across a clock boundary.
//  The sender holds iclk_data_i stable and flips a request toggle. This block

---
 rtl/bsg_sync_sync_handshake_rx.sv | 91 +++++++++
 tb/tb_bsg_sync_sync_handshake_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bsg_sync_sync_handshake_rx.sv
// Receive side of a toggle-handshake clock crossing: only the request toggle is
// synchronized; the wide bundle is captured once that toggle has settled.
module bsg_sync_sync_handshake_rx
  #(parameter int width_p       = 64
   ,parameter int sync_stages_p = 2
   ,parameter int count_width_p = 16)
  (input  logic                     clk_i
  ,input  logic                     reset_i
  ,input  logic                     iclk_req_toggle_i
  ,input  logic [width_p-1:0]       iclk_data_i
  ,output logic                     v_o
  ,output logic [width_p-1:0]       data_o
  ,input  logic                     yumi_i
  ,output logic                     ack_toggle_o
  ,output logic                     protocol_err_o
  ,output logic [count_width_p-1:0] count_o
  );

  localparam logic [0:0] idle_lp = 1'b0;
  localparam logic [0:0] hold_lp = 1'b1;

  logic [sync_stages_p-1:0] sync_r;
  logic                     req_seen_r;
  logic [0:0]               state_r;
  logic                     v_r;
  logic [width_p-1:0]       data_r;
  logic                     ack_r;
  logic                     err_r;
  logic [count_width_p-1:0] count_r;
  logic                     req_sync_s;
  logic                     new_req_s;

  assign req_sync_s = sync_r[sync_stages_p-1];
  assign new_req_s  = req_sync_s ^ req_seen_r;

  // Multi-flop synchronizer on the request toggle only
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[sync_stages_p-2:0], iclk_req_toggle_i};
    end
  end

  // Capture/hold/ack FSM; a toggle seen while holding is flagged but left pending,
  // so it is picked up as an ordinary transfer once the current one is consumed
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= idle_lp;
      req_seen_r <= 1'b0;
      v_r        <= 1'b0;
      data_r     <= '0;
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
      count_r    <= '0;
    end else begin
      case (state_r)
        idle_lp: begin
          if (new_req_s) begin
            data_r     <= iclk_data_i;
            req_seen_r <= req_sync_s;
            v_r        <= 1'b1;
            state_r    <= hold_lp;
          end
        end
        hold_lp: begin
          if (new_req_s) begin
            err_r <= 1'b1;
          end
          if (yumi_i) begin
            v_r     <= 1'b0;
            ack_r   <= ~ack_r;
            count_r <= count_r + {{(count_width_p-1){1'b0}}, 1'b1};
            state_r <= idle_lp;
          end
        end
        default: begin
          v_r     <= 1'b0;
          state_r <= idle_lp;
        end
      endcase
    end
  end

  assign v_o            = v_r;
  assign data_o         = data_r;
  assign ack_toggle_o   = ack_r;
  assign protocol_err_o = err_r;
  assign count_o        = count_r;

endmodule

// File: tb/tb_bsg_sync_sync_handshake_rx.sv
// Self-checking bench: randomized sender/consumer traffic compared against a
// transfer-level model (queue of sent bundles, consumed count, sticky error).
module tb_bsg_sync_sync_handshake_rx;

  localparam int width_p       = 64;
  localparam int sync_stages_p = 2;
  localparam int count_width_p = 8;

  logic                     clk_i;
  logic                     reset_i;
  logic                     iclk_req_toggle_i;
  logic [width_p-1:0]       iclk_data_i;
  logic                     v_o;
  logic [width_p-1:0]       data_o;
  logic                     yumi_i;
  logic                     ack_toggle_o;
  logic                     protocol_err_o;
  logic [count_width_p-1:0] count_o;

  bsg_sync_sync_handshake_rx
    #(.width_p(width_p), .sync_stages_p(sync_stages_p), .count_width_p(count_width_p))
  dut
    (.clk_i(clk_i)
    ,.reset_i(reset_i)
    ,.iclk_req_toggle_i(iclk_req_toggle_i)
    ,.iclk_data_i(iclk_data_i)
    ,.v_o(v_o)
    ,.data_o(data_o)
    ,.yumi_i(yumi_i)
    ,.ack_toggle_o(ack_toggle_o)
    ,.protocol_err_o(protocol_err_o)
    ,.count_o(count_o)
    );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks_r;
  int n_pass_r;

  // Reference model state: what the block should show at transfer level
  logic [width_p-1:0] sent_q[$];
  int                 consumed_m;
  logic               err_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks_r++;
    if (obs === exp) n_pass_r++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    iclk_req_toggle_i = 1'b0;
    iclk_data_i = '0;
    yumi_i = 1'b0;
    sent_q.delete();
    consumed_m = 0;
    err_m = 1'b0;
    repeat (2) step();
    reset_i = 1'b0;
  endtask

  task automatic send(input logic [width_p-1:0] d);
    iclk_data_i = d;
    iclk_req_toggle_i = ~iclk_req_toggle_i;
    sent_q.push_back(d);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!v_o && n < 20) begin
      step();
      n++;
    end
    if (!v_o) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic consume(input string tag);
    logic [width_p-1:0] exp_d;
    exp_d = sent_q.pop_front();
    check({tag, "_data"}, data_o, exp_d);
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    consumed_m++;
    check({tag, "_v_after"}, {63'd0, v_o}, 64'd0);
    check({tag, "_ack"}, {63'd0, ack_toggle_o}, 64'(consumed_m % 2));
    check({tag, "_count"}, {56'd0, count_o}, 64'(consumed_m % 256));
  endtask

  initial begin
    logic [width_p-1:0] d_a;
    logic [width_p-1:0] d_b;
    n_checks_r = 0;
    n_pass_r = 0;

    // Reset values
    do_reset();
    check("rst_v", {63'd0, v_o}, 64'd0);
    check("rst_data", data_o, 64'd0);
    check("rst_ack", {63'd0, ack_toggle_o}, 64'd0);
    check("rst_err", {63'd0, protocol_err_o}, 64'd0);
    check("rst_count", {56'd0, count_o}, 64'd0);

    // Latency: v_o rises after edge sync_stages_p+1
    send(64'hDEAD_BEEF_0123_4567);
    step();
    step();
    check("lat_v_edge2", {63'd0, v_o}, 64'd0);
    step();
    check("lat_v_edge3", {63'd0, v_o}, 64'd1);
    check("lat_data", data_o, 64'hDEAD_BEEF_0123_4567);
    check("lat_ack", {63'd0, ack_toggle_o}, 64'd0);

    // Hold without yumi: data and valid stay put
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_data", data_o, 64'hDEAD_BEEF_0123_4567);
      check("hold_v", {63'd0, v_o}, 64'd1);
    end
    check("hold_ack", {63'd0, ack_toggle_o}, 64'd0);
    consume("hold");

    // Closed loop: 300 random transfers from a fresh reset
    do_reset();
    for (int t = 0; t < 300; t++) begin
      #($urandom_range(0, 7));
      send({$urandom, $urandom});
      wait_valid("loop");
      repeat ($urandom_range(0, 3)) step();
      consume("loop");
    end
    check("loop_count_final", {56'd0, count_o}, 64'd44);
    check("loop_err", {63'd0, protocol_err_o}, {63'd0, err_m});

    // Second toggle while holding: flagged, pending transfer untouched
    d_a = {$urandom, $urandom};
    d_b = ~d_a;
    send(d_a);
    wait_valid("ovl_a");
    send(d_b);
    err_m = 1'b1;
    repeat (4) step();
    check("ovl_err", {63'd0, protocol_err_o}, {63'd0, err_m});
    check("ovl_hold_data", data_o, d_a);
    check("ovl_hold_v", {63'd0, v_o}, 64'd1);
    consume("ovl_a");
    step();
    check("ovl_b_v", {63'd0, v_o}, 64'd1);
    consume("ovl_b");
    check("ovl_err_sticky", {63'd0, protocol_err_o}, {63'd0, err_m});

    // yumi with nothing valid, then a sub-period toggle glitch
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    check("idle_yumi_ack", {63'd0, ack_toggle_o}, 64'(consumed_m % 2));
    check("idle_yumi_count", {56'd0, count_o}, 64'(consumed_m % 256));
    check("idle_yumi_v", {63'd0, v_o}, 64'd0);
    #1 iclk_req_toggle_i = ~iclk_req_toggle_i;
    #4 iclk_req_toggle_i = ~iclk_req_toggle_i;
    repeat (6) step();
    check("glitch_v", {63'd0, v_o}, 64'd0);
    check("glitch_count", {56'd0, count_o}, 64'(consumed_m % 256));
    check("glitch_ack", {63'd0, ack_toggle_o}, 64'(consumed_m % 2));

    // Asynchronous reset while holding
    send({$urandom, $urandom});
    wait_valid("arst");
    check("arst_pre_v", {63'd0, v_o}, 64'd1);
    #2 reset_i = 1'b1;
    #1;
    check("arst_v", {63'd0, v_o}, 64'd0);
    check("arst_ack", {63'd0, ack_toggle_o}, 64'd0);
    check("arst_count", {56'd0, count_o}, 64'd0);
    check("arst_err", {63'd0, protocol_err_o}, 64'd0);
    check("arst_data", data_o, 64'd0);
    do_reset();

    $display("%0d/%0d checks passed", n_pass_r, n_checks_r);
    $finish;
  end

endmodule
